vga_pixel_streamer: RTL and testbench
=====================================

Name: vga_pixel_streamer

Overview:
- FIFO consumer stage directly downstream of the SDRAM-to-FIFO Avalon read master.
- Generates 640x480@60 VGA timing from clk, which is the 25.175 MHz pixel clock.
- Pops one 32-bit pixel word per active pixel from the pixel FIFO (standard-mode read, 1-cycle read latency) and drives registered RGB/sync/blank to the DAC.
- Flags FIFO underflow and blanks the affected pixels.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  stream enable; 0 forces IDLE at next frame boundary
- fifo_empty  in  1  pixel FIFO empty
- fifo_rd_data  in  32  FIFO q; {8'x, R[23:16], G[15:8], B[7:0]}
- fifo_rd_en  out  1  FIFO read request (combinational from registered state)
- vga_hs  out  1  hsync, active low
- vga_vs  out  1  vsync, active low
- vga_blank_n  out  1  0 outside active area
- vga_sync_n  out  1  tied 0 (no sync-on-green)
- vga_r, vga_g, vga_b  out  8 each  pixel colour
- frame_start  out  1  1-cycle pulse when h_cnt=0, v_cnt=0
- underflow  out  1  sticky; set on any underflow, cleared by underflow_clr
- underflow_clr  in  1  synchronous clear of underflow and underflow_cnt
- underflow_cnt  out  16  saturating count of underflowed pixels

Behaviour:
- Counters: h_cnt 0..H_TOTAL-1 (H_TOTAL=800), v_cnt 0..V_TOTAL-1 (525). h_cnt wraps and increments v_cnt; v_cnt wraps to 0 after 524. Counters run in every state.
- active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- hs_raw low for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
- vs_raw low for v_cnt 490..491.
- FSM states:
  - IDLE: no reads. Go to WAIT_FRAME when enable=1.
  - WAIT_FRAME: no reads. Go to RUN when h_cnt=H_TOTAL-1 && v_cnt=V_TOTAL-1 && !fifo_empty && enable. Frame alignment: the first word read is pixel (0,0).
  - RUN: fifo_rd_en = active && !fifo_empty. At the last counter position of a frame, if enable=0, go to IDLE.
- Pipeline: counter-derived signals at cycle t; FIFO q valid at t+1; registered into outputs at the t+2 edge. hs, vs and blank_n are delayed through 2 register stages so all outputs are aligned. Total latency counter -> pins = 2 clocks.
- Colour: vga_r/g/b = fifo_rd_data[23:16]/[15:8]/[7:0] when the delayed read-valid bit is 1, else 0. Outside the active area, colour is always 0.
- Underflow (RUN && active && fifo_empty):
  - no read;
  - pixel output black;
  - underflow <= 1;
  - underflow_cnt increments, saturating at 16'hFFFF.
  - The stream is not realigned (the upstream master has no flush). Software recovers by toggling enable, which re-enters through WAIT_FRAME.
- underflow_clr and an underflow event in the same cycle: clear wins for underflow; underflow_cnt loads 0.
- frame_start is aligned with output-stage pixel (0,0), i.e. 2 clocks after counters = 0.
- Reset (any time, including mid-line):
  - counters 0, state IDLE, pipeline cleared;
  - vga_hs=1, vga_vs=1, vga_blank_n=0, rgb=0, fifo_rd_en=0, frame_start=0, underflow=0, underflow_cnt=0.
  - Output is valid from the first edge after deassertion.

Test Plan:
- Reset release, enable=0, FIFO empty: over 2 frames, vga_hs low exactly 96 clocks per 800, vga_vs low 2 lines per 525, blank_n high 640x480 per frame, fifo_rd_en never 1.
- enable=1, FIFO model preloaded with an incrementing pattern 0x000000.. (never empty): RUN entered at frame boundary; exactly 307200 reads per frame; pixel (0,0) at pins = 0x000000; pixel (639,479) = 0x04AFFF. Each colour appears 2 clocks after its read.
- Force fifo_empty=1 for 5 clocks mid-line in RUN: 5 black pixels; underflow=1; underflow_cnt=5; no rd_en during those cycles.
- Assert underflow_clr on the same cycle as an underflow: underflow=0, underflow_cnt=0.
- Drop enable mid-frame: reads continue to the end of the frame, then IDLE. Re-enable: reads resume at the next pixel (0,0) only.
- Assert reset_n=0 for 3 clocks mid active line: outputs take reset values immediately (async); after release, counters start at 0 and state is IDLE.

Source files
------------

// File: rtl/vga_pixel_streamer.sv
// VGA pixel streamer: 640x480@60 timing, pops one FIFO word per active pixel.
// Two-stage output pipeline keeps colour, syncs and blank aligned at the pins.
module vga_pixel_streamer #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [31:0] fifo_rd_data,
  output logic        fifo_rd_en,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        vga_sync_n,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        frame_start,
  output logic        underflow,
  input  logic        underflow_clr,
  output logic [15:0] underflow_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [1:0]    state_q, state_d;
  logic          h_last, frame_last, active;
  logic          hs_raw, vs_raw, run, rd_en, uf_ev;

  logic          rd_v1_q, act1_q, hs1_q, vs1_q, fs1_q;
  logic [23:0]   rgb_q, rgb_d;
  logic          hs_q, vs_q, blank_n_q, fs_q;
  logic          uf_q, uf_d;
  logic [15:0]   ucnt_q, ucnt_d;
  logic          unused_hi;

  assign unused_hi  = ^fifo_rd_data[31:24];

  assign h_last     = (h_cnt_q == H_LAST);
  assign frame_last = h_last && (v_cnt_q == V_LAST);
  assign active     = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign hs_raw     = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
  assign vs_raw     = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
  assign run        = (state_q == S_RUN);
  assign rd_en      = run && active && !fifo_empty;
  assign uf_ev      = run && active && fifo_empty;

  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_last) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    end
  end

  // WAIT_FRAME only arms on the last position so the first pop is pixel (0,0)
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (enable) state_d = S_WAIT;
      S_WAIT: begin
        if (frame_last) begin
          if (!enable)         state_d = S_IDLE;
          else if (!fifo_empty) state_d = S_RUN;
        end
      end
      S_RUN:  if (frame_last && !enable) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rgb_d = rd_v1_q ? fifo_rd_data[23:0] : 24'd0;
    uf_d  = uf_q;
    ucnt_d = ucnt_q;
    if (underflow_clr) begin
      uf_d   = 1'b0;
      ucnt_d = '0;
    end else if (uf_ev) begin
      uf_d = 1'b1;
      if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      state_q   <= S_IDLE;
      rd_v1_q   <= 1'b0;
      act1_q    <= 1'b0;
      hs1_q     <= 1'b1;
      vs1_q     <= 1'b1;
      fs1_q     <= 1'b0;
      rgb_q     <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      fs_q      <= 1'b0;
      uf_q      <= 1'b0;
      ucnt_q    <= '0;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      state_q   <= state_d;
      rd_v1_q   <= rd_en;
      act1_q    <= active;
      hs1_q     <= hs_raw;
      vs1_q     <= vs_raw;
      fs1_q     <= (h_cnt_q == '0) && (v_cnt_q == '0);
      rgb_q     <= rgb_d;
      hs_q      <= hs1_q;
      vs_q      <= vs1_q;
      blank_n_q <= act1_q;
      fs_q      <= fs1_q;
      uf_q      <= uf_d;
      ucnt_q    <= ucnt_d;
    end
  end

  assign fifo_rd_en    = rd_en;
  assign vga_hs        = hs_q;
  assign vga_vs        = vs_q;
  assign vga_blank_n   = blank_n_q;
  assign vga_sync_n    = 1'b0;
  assign vga_r         = rgb_q[23:16];
  assign vga_g         = rgb_q[15:8];
  assign vga_b         = rgb_q[7:0];
  assign frame_start   = fs_q;
  assign underflow     = uf_q;
  assign underflow_cnt = ucnt_q;

endmodule

// File: tb/tb_vga_pixel_streamer.sv
// Bench for vga_pixel_streamer on a shrunken 8x4 raster (16x9 total).
// FIFO model pushes expected colours; a monitor pops them at the pins.
module tb_vga_pixel_streamer;

  localparam int HT = 16;
  localparam int VT = 9;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        fifo_empty;
  logic [31:0] fifo_rd_data = 32'h0;
  logic        fifo_rd_en;
  logic        vga_hs, vga_vs, vga_blank_n, vga_sync_n;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        frame_start;
  logic        underflow;
  logic        underflow_clr;
  logic [15:0] underflow_cnt;

  vga_pixel_streamer #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .vga_hs       (vga_hs),
    .vga_vs       (vga_vs),
    .vga_blank_n  (vga_blank_n),
    .vga_sync_n   (vga_sync_n),
    .vga_r        (vga_r),
    .vga_g        (vga_g),
    .vga_b        (vga_b),
    .frame_start  (frame_start),
    .underflow    (underflow),
    .underflow_clr(underflow_clr),
    .underflow_cnt(underflow_cnt)
  );

  always #20 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [23:0] rgb;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n0 = 0;
  int   nvec = 0;
  int   nerr = 0;
  int   next_word = 0;
  logic pend = 1'b0;
  int   rd_total = 0, hs_low = 0, vs_low = 0, blk_hi = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  // FIFO model: a read seen during a cycle lands on q one edge later
  always @(negedge clk) begin
    if (reset_n && fifo_rd_en) begin
      q.push_back('{cyc: cyc + 2, rgb: next_word[23:0]});
      pend = 1'b1;
    end
  end

  always @(posedge clk) begin
    #1;
    if (pend) begin
      fifo_rd_data = {8'hA5, next_word[23:0]};
      next_word    = next_word + 1;
      pend         = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      rd_total += int'(fifo_rd_en);
      hs_low   += int'(!vga_hs);
      vs_low   += int'(!vga_vs);
      blk_hi   += int'(vga_blank_n);
    end
  end

  always @(negedge clk) begin
    logic [23:0] exp_rgb;
    if (!reset_n) begin
      q.delete();
    end else begin
      exp_rgb = 24'd0;
      while (q.size() > 0 && q[0].cyc < cyc) begin
        nvec++;
        nerr++;
        $display("FAIL stale_entry @cyc %0d: got none want %h", cyc, q[0].rgb);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) exp_rgb = q.pop_front().rgb;
      chk("pixel_rgb", {8'h0, vga_r, vga_g, vga_b}, {8'h0, exp_rgb});
      if (fifo_empty) chk("rd_en_while_empty", {31'h0, fifo_rd_en}, 32'h0);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int hpos();
    return ((cyc - n0) % FT) % HT;
  endfunction

  function automatic int vpos();
    return ((cyc - n0) % FT) / HT;
  endfunction

  task automatic goto_pos(input int h, input int v);
    int k;
    k = 0;
    do begin
      tick(1);
      k++;
    end while (!(hpos() == h && vpos() == v) && k < 2 * FT);
    if (k >= 2 * FT) chk("goto_pos_timeout", 32'h1, 32'h0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hs"},     {31'h0, vga_hs}, 32'h1);
    chk({tag, "_vs"},     {31'h0, vga_vs}, 32'h1);
    chk({tag, "_blank"},  {31'h0, vga_blank_n}, 32'h0);
    chk({tag, "_rgb"},    {8'h0, vga_r, vga_g, vga_b}, 32'h0);
    chk({tag, "_rd_en"},  {31'h0, fifo_rd_en}, 32'h0);
    chk({tag, "_fs"},     {31'h0, frame_start}, 32'h0);
    chk({tag, "_uf"},     {31'h0, underflow}, 32'h0);
    chk({tag, "_ufcnt"},  {16'h0, underflow_cnt}, 32'h0);
  endtask

  initial begin
    int snap_rd, snap_hs, snap_vs, snap_bk, k, r;
    reset_n       = 1'b0;
    enable        = 1'b0;
    fifo_empty    = 1'b1;
    underflow_clr = 1'b0;
    tick(3);
    chk_reset_vals("por");
    chk("sync_n", {31'h0, vga_sync_n}, 32'h0);
    reset_n = 1'b1;

    // idle timing over two frames
    tick(5);
    snap_rd = rd_total; snap_hs = hs_low; snap_vs = vs_low; snap_bk = blk_hi;
    tick(2 * FT);
    chk("idle_hs_low",  hs_low - snap_hs, 54);
    chk("idle_vs_low",  vs_low - snap_vs, 64);
    chk("idle_blank_hi", blk_hi - snap_bk, 64);
    chk("idle_reads",   rd_total - snap_rd, 0);

    // streaming with a never-empty FIFO
    fifo_empty = 1'b0;
    enable     = 1'b1;
    k = 0;
    while (!fifo_rd_en && k < 3 * FT) begin
      tick(1);
      k++;
    end
    chk("first_read_seen", {31'h0, fifo_rd_en}, 32'h1);
    n0 = cyc;
    snap_rd = rd_total;
    tick(2);
    chk("fs_at_px00",    {31'h0, frame_start}, 32'h1);
    chk("blank_at_px00", {31'h0, vga_blank_n}, 32'h1);
    chk("rgb_px00",      {8'h0, vga_r, vga_g, vga_b}, 32'h000000);
    tick(55);
    chk("rgb_px_last",   {8'h0, vga_r, vga_g, vga_b}, 32'h00001F);
    tick(1);
    chk("blank_after_last", {31'h0, vga_blank_n}, 32'h0);
    tick(n0 + FT - cyc);
    chk("reads_frame0", rd_total - snap_rd, 32);
    snap_rd = rd_total;
    tick(FT);
    chk("reads_frame1", rd_total - snap_rd, 32);
    chk("uf_clean", {31'h0, underflow}, 32'h0);

    // five-cycle underflow mid-line
    goto_pos(1, 1);
    fifo_empty = 1'b1;
    snap_rd = rd_total;
    tick(5);
    fifo_empty = 1'b0;
    chk("uf_reads", rd_total - snap_rd, 0);
    chk("uf_flag",  {31'h0, underflow}, 32'h1);
    chk("uf_cnt5",  {16'h0, underflow_cnt}, 32'd5);
    chk("uf_black", {7'h0, vga_blank_n, vga_r, vga_g, vga_b}, 32'h01000000);

    // clear colliding with an underflow event
    goto_pos(2, 2);
    fifo_empty    = 1'b1;
    underflow_clr = 1'b1;
    tick(1);
    fifo_empty    = 1'b0;
    underflow_clr = 1'b0;
    chk("clr_win_flag", {31'h0, underflow}, 32'h0);
    chk("clr_win_cnt",  {16'h0, underflow_cnt}, 32'h0);
    fifo_empty = 1'b1;
    tick(1);
    fifo_empty = 1'b0;
    chk("uf1_flag", {31'h0, underflow}, 32'h1);
    chk("uf1_cnt",  {16'h0, underflow_cnt}, 32'd1);
    underflow_clr = 1'b1;
    tick(1);
    underflow_clr = 1'b0;
    chk("clr_flag", {31'h0, underflow}, 32'h0);
    chk("clr_cnt",  {16'h0, underflow_cnt}, 32'h0);

    // disable mid-frame, then re-enable mid-frame
    goto_pos(2, 1);
    enable  = 1'b0;
    snap_rd = rd_total;
    goto_pos(0, 0);
    chk("drain_reads", rd_total - snap_rd, 22);
    snap_rd = rd_total;
    goto_pos(3, 2);
    chk("idle_after_drain", rd_total - snap_rd, 0);
    enable  = 1'b1;
    snap_rd = rd_total;
    goto_pos(0, 0);
    chk("no_early_reads", rd_total - snap_rd, 0);
    chk("resume_at_px00", {31'h0, fifo_rd_en}, 32'h1);
    snap_rd = rd_total;
    tick(FT);
    chk("reads_resumed", rd_total - snap_rd, 32);

    // async reset mid active line
    goto_pos(1, 1);
    fifo_empty = 1'b1;
    tick(1);
    fifo_empty = 1'b0;
    chk("pre_rst_uf", {16'h0, underflow_cnt}, 32'd1);
    goto_pos(3, 1);
    reset_n = 1'b0;
    #1;
    chk_reset_vals("async");
    tick(3);
    reset_n = 1'b1;
    r  = cyc;
    n0 = r;
    snap_rd = rd_total;
    chk("post_rst_rd", {31'h0, fifo_rd_en}, 32'h0);
    tick(1);
    chk("post_rst_fs_early", {31'h0, frame_start}, 32'h0);
    tick(1);
    chk("post_rst_fs", {31'h0, frame_start}, 32'h1);
    tick(r + FT - cyc);
    chk("post_rst_wait_reads", rd_total - snap_rd, 0);
    chk("post_rst_first_read", {31'h0, fifo_rd_en}, 32'h1);
    tick(20);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
